// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
// Holds the controller FSM state encoding, the EX operand-forward select
// encodings and the forward-select helper used for both EX operands.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDstall = 2'd1,
    StErr    = 2'd2
  } state_e;

  localparam logic [1:0] FwdReg = 2'b00;  // operand from register file
  localparam logic [1:0] FwdEm  = 2'b01;  // operand from EM alu_result
  localparam logic [1:0] FwdMw  = 2'b10;  // operand from WB result

  // The younger (EM) producer wins over WB; register 0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] em_dst,
                                         input logic       em_rw,
                                         input logic [4:0] mw_dst,
                                         input logic       mw_rw);
    if (em_rw && (em_dst != 5'd0) && (em_dst == src)) begin
      return FwdEm;
    end else if (mw_rw && (mw_dst != 5'd0) && (mw_dst == src)) begin
      return FwdMw;
    end
    return FwdReg;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Signal bundle between the hazard controller and the 5-stage datapath.
// master: the controller (samples stage fields, drives enables/flushes/selects).
// slave:  the datapath (drives stage fields and memory readiness).
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  // Stage fields from the datapath
  logic [4:0] id_rs, id_rt;
  logic       id_use_rs, id_use_rt;
  logic [4:0] de_rs, de_rt, de_dst_reg;
  logic       de_mem_read;
  logic [4:0] em_dst_reg;
  logic       em_reg_write, em_mem_read, em_mem_write;
  logic       em_branch, em_alu_zero, em_jmp;
  logic [4:0] mw_dst_reg;
  logic       mw_reg_write;
  logic       imem_ready, dmem_ready;
  // Controls back to the datapath
  logic       pc_wren, pc_sel;
  logic       fd_wren, de_wren, em_wren, mw_wren;
  logic       fd_flush, de_flush, em_flush;
  logic       dmem_req;
  logic [1:0] fwd_a, fwd_b;
  logic       bus_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    input  id_rs, id_rt, id_use_rs, id_use_rt,
    input  de_rs, de_rt, de_dst_reg, de_mem_read,
    input  em_dst_reg, em_reg_write, em_mem_read, em_mem_write,
    input  em_branch, em_alu_zero, em_jmp,
    input  mw_dst_reg, mw_reg_write, imem_ready, dmem_ready,
    output pc_wren, pc_sel, fd_wren, de_wren, em_wren, mw_wren,
    output fd_flush, de_flush, em_flush, dmem_req, fwd_a, fwd_b,
    output bus_err, stall_cnt, flush_cnt
  );

  modport slave (
    output id_rs, id_rt, id_use_rs, id_use_rt,
    output de_rs, de_rt, de_dst_reg, de_mem_read,
    output em_dst_reg, em_reg_write, em_mem_read, em_mem_write,
    output em_branch, em_alu_zero, em_jmp,
    output mw_dst_reg, mw_reg_write, imem_ready, dmem_ready,
    input  pc_wren, pc_sel, fd_wren, de_wren, em_wren, mw_wren,
    input  fd_flush, de_flush, em_flush, dmem_req, fwd_a, fwd_b,
    input  bus_err, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc_i, holds at all-ones, never wraps.
// Ports: clk, reset_n (async active-low), inc_i, cnt_o (CNT_W bits).
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for the IF/ID/EX/MEM/WB pipeline.
// Ports: clk, reset_n (async active-low), bus (pipeline_ctrl_if.master):
//   stage register/memory-ready inputs in; PC/stage write enables, bubble
//   flushes, pc_sel, dmem_req, EX forward selects, sticky bus_err and
//   saturating stall/flush counters out.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  pipeline_ctrl_if.master  bus
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;

  logic dmem_req, dstall, taken, loaduse;
  logic pc_wren, pc_sel, fd_wren, de_wren, em_wren, mw_wren;
  logic fd_flush, de_flush, em_flush;

  always_comb begin
    dmem_req = (bus.em_mem_read | bus.em_mem_write) & (state_q != StErr);
    dstall   = dmem_req & ~bus.dmem_ready;
    taken    = bus.em_jmp | (bus.em_branch & bus.em_alu_zero);
    loaduse  = bus.de_mem_read & (bus.de_dst_reg != 5'd0) &
               ((bus.id_use_rs & (bus.id_rs == bus.de_dst_reg)) |
                (bus.id_use_rt & (bus.id_rt == bus.de_dst_reg)));
  end

  // Next state and stall-length tracking
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    unique case (state_q)
      StRun: begin
        if (dstall) begin
          state_d    = StDstall;
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StDstall: begin
        if (!dstall) begin
          state_d = StRun;
        end else if (wait_cnt_q == WaitLast) begin
          state_d = StErr;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StErr:   state_d = StErr;
      default: state_d = StErr;
    endcase
  end

  // Pipeline control, highest priority first
  always_comb begin
    pc_wren  = 1'b1;
    pc_sel   = 1'b0;
    fd_wren  = 1'b1;
    de_wren  = 1'b1;
    em_wren  = 1'b1;
    mw_wren  = 1'b1;
    fd_flush = 1'b0;
    de_flush = 1'b0;
    em_flush = 1'b0;
    if ((state_q == StErr) || dstall) begin
      // Full freeze; a frozen WB just repeats the same register write.
      pc_wren = 1'b0;
      fd_wren = 1'b0;
      de_wren = 1'b0;
      em_wren = 1'b0;
      mw_wren = 1'b0;
    end else if (taken) begin
      pc_sel   = 1'b1;
      fd_flush = 1'b1;
      de_flush = 1'b1;
      em_flush = 1'b1;
    end else if (loaduse || !bus.imem_ready) begin
      // Hold PC/IF-ID, inject a bubble into EX, let downstream drain.
      pc_wren  = 1'b0;
      fd_wren  = 1'b0;
      de_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Controls are forced low while reset is asserted
  assign bus.pc_wren  = pc_wren  & reset_n;
  assign bus.pc_sel   = pc_sel   & reset_n;
  assign bus.fd_wren  = fd_wren  & reset_n;
  assign bus.de_wren  = de_wren  & reset_n;
  assign bus.em_wren  = em_wren  & reset_n;
  assign bus.mw_wren  = mw_wren  & reset_n;
  assign bus.fd_flush = fd_flush & reset_n;
  assign bus.de_flush = de_flush & reset_n;
  assign bus.em_flush = em_flush & reset_n;
  assign bus.dmem_req = dmem_req & reset_n;
  assign bus.bus_err  = (state_q == StErr);

  assign bus.fwd_a = fwd_sel(bus.de_rs, bus.em_dst_reg, bus.em_reg_write,
                             bus.mw_dst_reg, bus.mw_reg_write);
  assign bus.fwd_b = fwd_sel(bus.de_rt, bus.em_dst_reg, bus.em_reg_write,
                             bus.mw_dst_reg, bus.mw_reg_write);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (~pc_wren),
    .cnt_o   (bus.stall_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (pc_sel),
    .cnt_o   (bus.flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (MAX_WAIT=4, CNT_W=2 so saturation is reachable).
module tb_pipeline_ctrl;

  localparam int unsigned MaxWait = 4;
  localparam int unsigned CntW    = 2;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;

  pipeline_ctrl_if #(.CNT_W(CntW)) u_if ();

  pipeline_ctrl #(
    .MAX_WAIT (MaxWait),
    .CNT_W    (CntW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    u_if.id_rs = 5'd0;        u_if.id_rt = 5'd0;
    u_if.id_use_rs = 1'b0;    u_if.id_use_rt = 1'b0;
    u_if.de_rs = 5'd0;        u_if.de_rt = 5'd0;
    u_if.de_dst_reg = 5'd0;   u_if.de_mem_read = 1'b0;
    u_if.em_dst_reg = 5'd0;   u_if.em_reg_write = 1'b0;
    u_if.em_mem_read = 1'b0;  u_if.em_mem_write = 1'b0;
    u_if.em_branch = 1'b0;    u_if.em_alu_zero = 1'b0;
    u_if.em_jmp = 1'b0;
    u_if.mw_dst_reg = 5'd0;   u_if.mw_reg_write = 1'b0;
    u_if.imem_ready = 1'b1;   u_if.dmem_ready = 1'b1;
  endtask

  // {pc_wren, fd_wren, de_wren, em_wren, mw_wren}
  function automatic logic [4:0] wrens();
    return {u_if.pc_wren, u_if.fd_wren, u_if.de_wren, u_if.em_wren, u_if.mw_wren};
  endfunction

  // {pc_sel, fd_flush, de_flush, em_flush}
  function automatic logic [3:0] flushes();
    return {u_if.pc_sel, u_if.fd_flush, u_if.de_flush, u_if.em_flush};
  endfunction

  task automatic pulse_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_stall_cnt", 32'(u_if.stall_cnt), 0);
    check_eq("rst_flush_cnt", 32'(u_if.flush_cnt), 0);
    check_eq("rst_bus_err", 32'(u_if.bus_err), 0);
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    clear_inputs();
    u_if.em_mem_read = 1'b1;

    // Reset state: controls low even with a pending memory op
    tick();
    tick();
    check_eq("rst_wrens", 32'(wrens()), 0);
    check_eq("rst_flushes", 32'(flushes()), 0);
    check_eq("rst_dmem_req", 32'(u_if.dmem_req), 0);
    reset_n = 1'b1;
    u_if.em_mem_read = 1'b0;
    #1;
    check_eq("idle_wrens", 32'(wrens()), 5'b11111);
    check_eq("idle_flushes", 32'(flushes()), 0);
    tick();
    check_eq("idle_stall_cnt", 32'(u_if.stall_cnt), 0);

    // Load-use: lw r5 in EX, ID reads r5
    u_if.de_mem_read = 1'b1; u_if.de_dst_reg = 5'd5;
    u_if.id_rs = 5'd5;       u_if.id_use_rs = 1'b1;
    #1;
    check_eq("lu_wrens", 32'(wrens()), 5'b00111);
    check_eq("lu_flushes", 32'(flushes()), 4'b0010);
    tick();
    u_if.de_mem_read = 1'b0;
    #1;
    check_eq("lu_stall_cnt", 32'(u_if.stall_cnt), 1);
    check_eq("lu_gone_wrens", 32'(wrens()), 5'b11111);
    // Register 0 never stalls
    u_if.de_mem_read = 1'b1; u_if.de_dst_reg = 5'd0; u_if.id_rs = 5'd0;
    #1;
    check_eq("lu_r0_wrens", 32'(wrens()), 5'b11111);
    // rt path
    u_if.id_use_rs = 1'b0; u_if.de_dst_reg = 5'd9;
    u_if.id_rt = 5'd9;     u_if.id_use_rt = 1'b1;
    #1;
    check_eq("lu_rt_wrens", 32'(wrens()), 5'b00111);
    u_if.id_use_rt = 1'b0;
    tick();
    check_eq("lu_r0_stall_cnt", 32'(u_if.stall_cnt), 1);

    // Taken branch wins over load-use and an imem wait
    u_if.de_mem_read = 1'b1; u_if.de_dst_reg = 5'd5;
    u_if.id_rs = 5'd5;       u_if.id_use_rs = 1'b1;
    u_if.imem_ready = 1'b0;
    u_if.em_branch = 1'b1;   u_if.em_alu_zero = 1'b1;
    #1;
    check_eq("br_wrens", 32'(wrens()), 5'b11111);
    check_eq("br_flushes", 32'(flushes()), 4'b1111);
    tick();
    check_eq("br_flush_cnt", 32'(u_if.flush_cnt), 1);
    check_eq("br_stall_cnt", 32'(u_if.stall_cnt), 1);
    // Not taken: load-use takes over
    u_if.em_alu_zero = 1'b0;
    #1;
    check_eq("nt_flushes", 32'(flushes()), 4'b0010);
    check_eq("nt_wrens", 32'(wrens()), 5'b00111);
    // imem wait alone
    u_if.de_mem_read = 1'b0; u_if.em_branch = 1'b0;
    #1;
    check_eq("imem_wrens", 32'(wrens()), 5'b00111);
    check_eq("imem_flushes", 32'(flushes()), 4'b0010);
    clear_inputs();
    #1;
    tick();

    // Jumps saturate flush_cnt at 3
    u_if.em_jmp = 1'b1;
    #1;
    check_eq("jmp_flushes", 32'(flushes()), 4'b1111);
    for (int i = 0; i < 3; i++) tick();
    check_eq("jmp_flush_sat", 32'(u_if.flush_cnt), 3);
    u_if.em_jmp = 1'b0;

    // Data wait: 3 stalled cycles then ready; a taken branch is held off
    u_if.em_mem_read = 1'b1; u_if.dmem_ready = 1'b0; u_if.em_jmp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("dw_wrens_%0d", i), 32'(wrens()), 0);
      check_eq($sformatf("dw_flushes_%0d", i), 32'(flushes()), 0);
      check_eq($sformatf("dw_req_%0d", i), 32'(u_if.dmem_req), 1);
      tick();
    end
    u_if.dmem_ready = 1'b1; u_if.em_jmp = 1'b0;
    #1;
    check_eq("dw_done_wrens", 32'(wrens()), 5'b11111);
    tick();
    check_eq("dw_bus_err", 32'(u_if.bus_err), 0);
    // 1 + 3 stalled edges saturates a 2-bit counter
    check_eq("dw_stall_sat", 32'(u_if.stall_cnt), 3);
    check_eq("dw_run_wrens", 32'(wrens()), 5'b11111);
    clear_inputs();
    pulse_reset();

    // Timeout after MAX_WAIT stalled cycles
    u_if.em_mem_read = 1'b1; u_if.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("to_pre_err_%0d", i), 32'(u_if.bus_err), 0);
    end
    tick();
    check_eq("to_bus_err", 32'(u_if.bus_err), 1);
    u_if.dmem_ready = 1'b1;
    #1;
    check_eq("err_dmem_req", 32'(u_if.dmem_req), 0);
    check_eq("err_wrens", 32'(wrens()), 0);
    u_if.em_jmp = 1'b1;
    #1;
    check_eq("err_flushes", 32'(flushes()), 0);
    tick();
    tick();
    check_eq("err_sticky", 32'(u_if.bus_err), 1);
    check_eq("err_stall_cnt", 32'(u_if.stall_cnt), 3);
    check_eq("err_flush_cnt", 32'(u_if.flush_cnt), 0);
    clear_inputs();
    pulse_reset();
    check_eq("post_err_wrens", 32'(wrens()), 5'b11111);

    // Async reset in the middle of a data stall
    u_if.em_mem_read = 1'b1; u_if.dmem_ready = 1'b0;
    tick();
    check_eq("ar_stall_cnt", 32'(u_if.stall_cnt), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("ar_dmem_req", 32'(u_if.dmem_req), 0);
    check_eq("ar_stall_clr", 32'(u_if.stall_cnt), 0);
    check_eq("ar_wrens", 32'(wrens()), 0);
    reset_n = 1'b1;
    u_if.dmem_ready = 1'b1;
    #1;
    check_eq("ar_rel_req", 32'(u_if.dmem_req), 1);
    check_eq("ar_rel_wrens", 32'(wrens()), 5'b11111);
    clear_inputs();

    // Forwarding
    u_if.de_rs = 5'd7; u_if.de_rt = 5'd7;
    u_if.em_dst_reg = 5'd7; u_if.em_reg_write = 1'b1;
    u_if.mw_dst_reg = 5'd7; u_if.mw_reg_write = 1'b1;
    #1;
    check_eq("fwd_a_em", 32'(u_if.fwd_a), 2'b01);
    check_eq("fwd_b_em", 32'(u_if.fwd_b), 2'b01);
    u_if.em_reg_write = 1'b0;
    #1;
    check_eq("fwd_a_mw", 32'(u_if.fwd_a), 2'b10);
    check_eq("fwd_b_mw", 32'(u_if.fwd_b), 2'b10);
    u_if.em_reg_write = 1'b1; u_if.em_dst_reg = 5'd0;
    #1;
    check_eq("fwd_a_em0", 32'(u_if.fwd_a), 2'b10);
    u_if.mw_dst_reg = 5'd0;
    #1;
    check_eq("fwd_a_none", 32'(u_if.fwd_a), 2'b00);
    check_eq("fwd_b_none", 32'(u_if.fwd_b), 2'b00);
    u_if.em_dst_reg = 5'd7; u_if.de_rt = 5'd3;
    #1;
    check_eq("fwd_a_split", 32'(u_if.fwd_a), 2'b01);
    check_eq("fwd_b_split", 32'(u_if.fwd_b), 2'b00);
    u_if.mw_dst_reg = 5'd3;
    #1;
    check_eq("fwd_b_mw_rt", 32'(u_if.fwd_b), 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Hazard and stall controller for the 5-stage IF/ID/EX/MEM/WB pipeline.
- Drives the write enables of the PC and the four stage registers, and drives bubble-injection (flush) selects.
- Resolves load-use hazards, taken branches/jumps, instruction and data memory wait states, and EX operand forwarding.
- Keeps saturating stall/flush performance counters and a sticky data-bus timeout error.

Parameters:
MAX_WAIT, 16, consecutive data-memory stall cycles tolerated before bus error (>=2)
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
id_rs  in  5  ID-stage source register A
id_rt  in  5  ID-stage source register B
id_use_rs  in  1  ID instruction reads id_rs
id_use_rt  in  1  ID instruction reads id_rt
de_rs  in  5  EX-stage source register A
de_rt  in  5  EX-stage source register B
de_dst_reg  in  5  EX-stage destination
de_mem_read  in  1  EX-stage instruction is a load
em_dst_reg  in  5  MEM-stage destination
em_reg_write  in  1  MEM-stage writes a register
em_mem_read  in  1  MEM-stage load
em_mem_write  in  1  MEM-stage store
em_branch  in  1  MEM-stage conditional branch
em_alu_zero  in  1  MEM-stage ALU zero flag
em_jmp  in  1  MEM-stage unconditional jump
mw_dst_reg  in  5  WB-stage destination
mw_reg_write  in  1  WB-stage writes a register
imem_ready  in  1  instruction memory data valid this cycle
dmem_ready  in  1  data memory access completes this cycle
pc_wren  out  1  PC write enable
pc_sel  out  1  1 = load branch_pc, 0 = sequential next_pc
fd_wren, de_wren, em_wren, mw_wren  out  1 each  stage register write enables
fd_flush, de_flush, em_flush  out  1 each  top level zeroes instruction/control inputs of that register (bubble)
dmem_req  out  1  data memory request
fwd_a, fwd_b  out  2 each  EX operand select: 00 register file, 01 EM alu_result, 10 WB result
bus_err  out  1  sticky data-memory timeout
stall_cnt  out  CNT_W  saturating count of cycles with pc_wren=0
flush_cnt  out  CNT_W  saturating count of taken branches/jumps

Behaviour:
- Reset (async assert, synchronous-safe deassert):
  - state=RUN, wait_cnt=0, counters=0, bus_err=0.
  - While reset_n=0 all wren, flush, pc_sel and dmem_req outputs are 0. fwd_* follow their combinational equations.
- States: RUN, DSTALL, ERR.
- dmem_req = (em_mem_read|em_mem_write) & state!=ERR.
- dstall = dmem_req & !dmem_ready.
- taken = em_jmp | (em_branch & em_alu_zero).
- loaduse = de_mem_read & de_dst_reg!=0 & ((id_use_rs & id_rs==de_dst_reg) | (id_use_rt & id_rt==de_dst_reg)).
- Priority, highest first; defaults are all wren=1, flush=0, pc_sel=0:
  1. ERR: all wren=0, no flush; pipeline halted until reset.
  2. dstall: all five wren=0, flushes 0 (full freeze; WB repeats the same write, which is harmless).
  3. taken: pc_sel=1, pc_wren=1, fd_flush=de_flush=em_flush=1; flush_cnt+1. Branch wins over loaduse and an imem wait.
  4. loaduse: pc_wren=fd_wren=0, de_flush=1, exactly one bubble; the next cycle the hazard is gone.
  5. !imem_ready: pc_wren=fd_wren=0, de_flush=1; downstream stages drain.
- FSM transitions:
  - RUN->DSTALL when dstall.
  - DSTALL->RUN when dmem_ready.
  - DSTALL->ERR when dstall has held for MAX_WAIT consecutive cycles (wait_cnt reaches MAX_WAIT-1 while still stalled); bus_err=1 from that edge.
  - ERR exits only on reset.
  - wait_cnt clears on every non-stalled cycle.
- Forwarding (fwd_a shown; fwd_b identical using de_rt):
  - 01 if em_reg_write & em_dst_reg!=0 & em_dst_reg==de_rs.
  - else 10 if mw_reg_write & mw_dst_reg!=0 & mw_dst_reg==de_rs.
  - else 00. The EM match wins over the WB match.
- Register 0 never triggers a hazard or a forward.
- Counters: stall_cnt increments on any cycle with pc_wren=0 outside reset, including ERR. Both counters saturate at all-ones and never wrap.

Decomposition:
- Shared include pipeline_ctrl_defs: FWD_REG/FWD_EM/FWD_MW encodings and the RUN/DSTALL/ERR state encodings.
- One sub-module, sat_counter (CNT_W, async reset_n, inc), instanced twice.
- Hazard, forwarding and priority logic stay inline.

Test Plan:
- Load-use: lw r5 in EX (de_mem_read=1, de_dst_reg=5), ID id_rs=5 with id_use_rs=1 -> one cycle of pc_wren=fd_wren=0, de_flush=1, stall_cnt 0->1. Same with id_rs=0 -> no stall.
- Taken branch: em_branch=1, em_alu_zero=1, simultaneous loaduse and imem_ready=0 -> pc_sel=1, pc_wren=1, three flushes, flush_cnt=1. With em_alu_zero=0 -> no action.
- Data wait: em_mem_read=1, dmem_ready low 3 cycles then high -> all wren=0 for exactly 3 cycles, state returns to RUN, no bus_err.
- Timeout: MAX_WAIT=4, dmem_ready held low -> bus_err=1 after the 4th stalled cycle. All wren stay 0 and dmem_req=0 until reset_n pulse, which clears bus_err and counters.
- Forwarding: de_rs=de_rt=7, em_dst_reg=7 em_reg_write=1, mw_dst_reg=7 mw_reg_write=1 -> fwd_a=fwd_b=01. Drop em_reg_write -> 10. Dst 0 -> 00.
- Async reset mid-DSTALL and counter saturation: reset_n asserted mid-DSTALL -> outputs go to 0 before the next clk edge. Separately, with CNT_W=2 and 5 stall cycles -> stall_cnt holds at 3.
